// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants and the set-2 letter map for the PS/2 key decoder.
package ps2_pkg;

  localparam int LETTER_W = 5;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_END   = 8'h69;
  localparam logic [7:0] SC_INS   = 8'h70;
  localparam logic [7:0] SC_DEL   = 8'h71;

  // Returns {valid, index}; index 0 is A, 25 is Z.
  function automatic logic [5:0] sc_to_letter(input logic [7:0] code);
    logic [5:0] r;
    r = '0;
    case (code)
      8'h1C: r = {1'b1, 5'd0};
      8'h32: r = {1'b1, 5'd1};
      8'h21: r = {1'b1, 5'd2};
      8'h23: r = {1'b1, 5'd3};
      8'h24: r = {1'b1, 5'd4};
      8'h2B: r = {1'b1, 5'd5};
      8'h34: r = {1'b1, 5'd6};
      8'h33: r = {1'b1, 5'd7};
      8'h43: r = {1'b1, 5'd8};
      8'h3B: r = {1'b1, 5'd9};
      8'h42: r = {1'b1, 5'd10};
      8'h4B: r = {1'b1, 5'd11};
      8'h3A: r = {1'b1, 5'd12};
      8'h31: r = {1'b1, 5'd13};
      8'h44: r = {1'b1, 5'd14};
      8'h4D: r = {1'b1, 5'd15};
      8'h15: r = {1'b1, 5'd16};
      8'h2D: r = {1'b1, 5'd17};
      8'h1B: r = {1'b1, 5'd18};
      8'h2C: r = {1'b1, 5'd19};
      8'h3C: r = {1'b1, 5'd20};
      8'h2A: r = {1'b1, 5'd21};
      8'h1D: r = {1'b1, 5'd22};
      8'h22: r = {1'b1, 5'd23};
      8'h35: r = {1'b1, 5'd24};
      8'h1A: r = {1'b1, 5'd25};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Command pulses and letter index handed from the key decoder to the game controller.
interface ps2_key_if;
  import ps2_pkg::*;

  logic                load;
  logic [LETTER_W-1:0] letter;
  logic                endinput;
  logic                start;
  logic                try;
  logic                wipe;
  logic                frame_err;

  modport master (output load, letter, endinput, start, try, wipe, frame_err);
  modport slave  (input  load, letter, endinput, start, try, wipe, frame_err);
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, frame FSM and inter-edge timeout.
// state    | meaning
// IDLE     | waiting for the start-bit falling edge
// DATA     | shifting in 8 data bits, LSB first
// PARITY   | capturing the parity bit
// STOP     | checking the stop bit and frame validity
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       timed_out
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic          clk_s1, clk_s2, clk_s3, fall_q;
  logic          dat_s1, dat_s2;
  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          start_bad, par_bit;
  logic [TW-1:0] tmo_cnt;

  assign byte_data = shreg;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      // Idle pins are high; resetting the chain high avoids a phantom falling edge.
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      clk_s3     <= 1'b1;
      fall_q     <= 1'b0;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      start_bad  <= 1'b0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      clk_s1     <= ps2_clk;
      clk_s2     <= clk_s1;
      clk_s3     <= clk_s2;
      fall_q     <= clk_s3 & ~clk_s2;
      dat_s1     <= ps2_dat;
      dat_s2     <= dat_s1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      timed_out  <= 1'b0;

      if (fall_q) begin
        tmo_cnt <= '0;
        case (state)
          ST_IDLE: begin
            start_bad <= dat_s2;
            bit_cnt   <= '0;
            state     <= ST_DATA;
          end
          ST_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat_s2;
            state   <= ST_STOP;
          end
          default: begin
            if (!start_bad && (^{shreg, par_bit}) && dat_s2) byte_valid <= 1'b1;
            else frame_err <= 1'b1;
            state <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (tmo_cnt == TW'(TIMEOUT_CYC)) begin
          frame_err <= 1'b1;
          timed_out <= 1'b1;
          tmo_cnt   <= '0;
          state     <= ST_IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Hangman front end: decodes PS/2 set-2 bytes into one-cycle game commands with typematic suppression.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 50_000_000,
  parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      ps2_clk,
  input  logic      ps2_dat,
  ps2_key_if.master keys
);

  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * FRAME_TIMEOUT_US;

  logic       byte_valid, rx_err, rx_tmo;
  logic [7:0] byte_data;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (rx_err),
    .timed_out  (rx_tmo)
  );

  logic                ext, brk, held_ext;
  logic [7:0]          held;
  logic                load_q, endinput_q, start_q, try_q, wipe_q, err_q;
  logic [LETTER_W-1:0] letter_q;
  logic                same_key;
  logic [5:0]          lt;

  assign same_key = (byte_data == held) && (held_ext == ext);
  assign lt       = sc_to_letter(byte_data);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      held       <= '0;
      held_ext   <= 1'b0;
      load_q     <= 1'b0;
      endinput_q <= 1'b0;
      start_q    <= 1'b0;
      try_q      <= 1'b0;
      wipe_q     <= 1'b0;
      err_q      <= 1'b0;
      letter_q   <= '0;
    end else begin
      load_q     <= 1'b0;
      endinput_q <= 1'b0;
      start_q    <= 1'b0;
      try_q      <= 1'b0;
      wipe_q     <= 1'b0;
      err_q      <= rx_err;

      // A timeout keeps a pending prefix alive; a corrupted frame discards it.
      if (rx_err && !rx_tmo) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end

      if (byte_valid) begin
        if (byte_data == SC_EXT) begin
          ext <= 1'b1;
        end else if (byte_data == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (brk) begin
            if (same_key) begin
              held     <= '0;
              held_ext <= 1'b0;
            end
          end else if (!same_key) begin
            held     <= byte_data;
            held_ext <= ext;
            if (!ext) begin
              if (lt[5]) begin
                load_q   <= 1'b1;
                letter_q <= lt[4:0];
              end else if (byte_data == SC_ENTER) begin
                start_q <= 1'b1;
              end
            end else begin
              case (byte_data)
                SC_END:  endinput_q <= 1'b1;
                SC_INS:  try_q      <= 1'b1;
                SC_DEL:  wipe_q     <= 1'b1;
                default: ;
              endcase
            end
          end
        end
      end
    end
  end

  assign keys.load      = load_q;
  assign keys.letter    = letter_q;
  assign keys.endinput  = endinput_q;
  assign keys.start     = start_q;
  assign keys.try       = try_q;
  assign keys.wipe      = wipe_q;
  assign keys.frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a key-level reference model predicts command pulses.
module tb_ps2_key_decoder;

  localparam int HALF = 20;
  localparam int GAP  = 60;

  localparam int K_LOAD = 0, K_END = 1, K_START = 2, K_TRY = 3, K_WIPE = 4, K_ERR = 5;

  typedef struct {
    int kind;
    int idx;
  } ev_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_key_if ko ();

  ps2_key_decoder #(.CLK_HZ(50_000_000), .FRAME_TIMEOUT_US(10)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .keys    (ko)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  int  fall_cyc = 0;
  bit  lat_chk = 1'b0;

  logic [7:0] lc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                          8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                          8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] ext_keys [3] = '{8'h69, 8'h70, 8'h71};

  // Reference model state: what the keyboard protocol says is pending and held down.
  bit         m_ext, m_brk, m_held_ext;
  logic [7:0] m_held;

  function automatic void push(input int kind, input int idx);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_held = 8'h00; m_held_ext = 0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (m_brk) begin
        if (m_held == b && m_held_ext == m_ext) begin m_held = 8'h00; m_held_ext = 0; end
      end else if (!(m_held == b && m_held_ext == m_ext)) begin
        m_held = b;
        m_held_ext = m_ext;
        if (!m_ext) begin
          for (int i = 0; i < 26; i++) if (lc[i] == b) push(K_LOAD, i);
          if (b == 8'h5A) push(K_START, 0);
        end else begin
          if (b == 8'h69) push(K_END, 0);
          if (b == 8'h70) push(K_TRY, 0);
          if (b == 8'h71) push(K_WIPE, 0);
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~(^b)) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF);
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 1'b0, 11);
    wait_cyc(GAP);
  endtask

  task automatic send_bad(input logic [7:0] b);
    push(K_ERR, 0);
    m_ext = 0; m_brk = 0;
    send_frame(b, 1'b1, 11);
    wait_cyc(GAP);
  endtask

  task automatic check_idle_outputs(input string name);
    logic [10:0] got;
    got = {ko.load, ko.endinput, ko.start, ko.try, ko.wipe, ko.frame_err, ko.letter};
    checks++;
    if (got != 11'd0) begin
      errors++;
      $display("FAIL %s: outputs {load,end,start,try,wipe,err,letter}=%b, required all 0", name, got);
    end
  endtask

  always @(negedge clk) begin
    int  n, k;
    ev_t e;
    n = int'(ko.load) + int'(ko.endinput) + int'(ko.start) + int'(ko.try) +
        int'(ko.wipe) + int'(ko.frame_err);
    if (n > 0) begin
      k = ko.load ? K_LOAD : ko.endinput ? K_END : ko.start ? K_START :
          ko.try ? K_TRY : ko.wipe ? K_WIPE : K_ERR;
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL multi_pulse: %0d pulses in one cycle, required 1", n);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: kind %0d letter %0d, required no pulse", k, ko.letter);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || (k == K_LOAD && int'(ko.letter) != e.idx)) begin
          errors++;
          $display("FAIL pulse_mismatch: kind %0d letter %0d, required kind %0d letter %0d",
                   k, ko.letter, e.kind, e.idx);
        end
      end
      if (lat_chk && k == K_START) begin
        lat_chk = 1'b0;
        checks++;
        if (cyc - fall_cyc != 5) begin
          errors++;
          $display("FAIL start_latency: %0d edges after final ps2_clk fall, required 5",
                   cyc - fall_cyc);
        end
      end
    end
  end

  initial begin
    int r, li;
    model_reset();
    wait_cyc(5);
    check_idle_outputs("reset_state");
    resetn = 1'b0;
    wait_cyc(20);

    // press/release A
    send_good(8'h1C); send_good(8'hF0); send_good(8'h1C);
    // typematic E, release, press again
    send_good(8'h24); send_good(8'h24); send_good(8'h24);
    send_good(8'hF0); send_good(8'h24); send_good(8'h24);
    // extended keys and Enter
    send_good(8'hE0); send_good(8'h70);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h70);
    send_good(8'hE0); send_good(8'h71);
    send_good(8'h5A);
    send_good(8'hE0); send_good(8'h69);
    // parity error, then B
    send_bad(8'h1C);
    send_good(8'h32);
    // a bad frame after a break prefix discards the prefix
    send_good(8'hF0); send_bad(8'h32); send_good(8'h1C);
    // timeout after E0 keeps ext pending; then Z
    send_good(8'hE0);
    push(K_ERR, 0);
    send_frame(8'h70, 1'b0, 5);
    wait_cyc(700);
    send_good(8'h70);
    send_good(8'h1A);

    // reset during parity bit of Enter
    send_frame(8'h5A, 1'b0, 9);
    ps2_dat = ~(^8'h5A);
    wait_cyc(HALF / 2);
    resetn = 1'b1;
    model_reset();
    wait_cyc(3);
    check_idle_outputs("reset_midframe");
    ps2_dat = 1'b1;
    wait_cyc(30);
    check_idle_outputs("reset_hold");
    resetn = 1'b0;
    wait_cyc(40);
    lat_chk = 1'b1;
    send_good(8'h5A);
    checks++;
    if (lat_chk) begin
      errors++;
      lat_chk = 1'b0;
      $display("FAIL start_after_reset: no start pulse seen, required one");
    end

    // randomized key traffic
    for (int it = 0; it < 30; it++) begin
      r  = $urandom_range(0, 9);
      li = $urandom_range(0, 3);
      case (r)
        0, 1, 2, 3: send_good(lc[li]);
        4: begin send_good(8'hF0); send_good(lc[li]); end
        5: begin
          send_good(8'hE0);
          if ($urandom_range(0, 1) == 1) send_good(8'hF0);
          send_good(ext_keys[$urandom_range(0, 2)]);
        end
        6: send_good(8'h5A);
        7: send_bad(8'($urandom_range(0, 255)));
        8: send_good(8'($urandom_range(0, 255)));
        default: begin send_good(8'hF0); send_good(8'h5A); end
      endcase
    end

    wait_cyc(200);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
